// File: rtl/wordle_letter_tx.sv
// Wordle letter-entry transmitter: cursor over a letter ring, commits letters over a valid/Ack handshake.
// Optional backspace token (8'h08 on BtnL) is built when WORDLE_TX_BACKSPACE_EN is defined.
module wordle_letter_tx #(
  parameter logic [7:0] FIRST_CHAR = 8'h41,
  parameter int         NUM_CHARS  = 26,
  parameter int         WORD_LEN   = 5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnC,
  input  logic       BtnL,
  input  logic       Ack,
  output logic [7:0] sel_letter,
  output logic [7:0] curr_letter,
  output logic       letter_valid,
  output logic [2:0] letter_count,
  output logic       word_done
);

  typedef enum logic [3:0] {
    QIDLE = 4'b0001,
    QSEL  = 4'b0010,
    QSEND = 4'b0100,
    QFULL = 4'b1000
  } state_t;

  localparam logic [7:0] LAST_CHAR  = FIRST_CHAR + 8'(NUM_CHARS - 1);
  localparam logic [2:0] WORD_LEN_C = 3'(WORD_LEN);
  localparam logic [7:0] BS_CHAR    = 8'h08;

  state_t     state_q;
  logic [7:0] sel_q;
  logic [7:0] curr_q;
  logic       valid_q;
  logic [2:0] cnt_q;
  logic       done_q;
  logic       bs_q;
  logic [7:0] sel_step_d;
  logic [2:0] cnt_inc_d;

  // Cursor moves one step around the ring; simultaneous up/down cancel out.
  function automatic logic [7:0] cursor_step(input logic [7:0] cur, input logic up, input logic dn);
    logic [7:0] nxt;
    nxt = cur;
    if (up && !dn) begin
      nxt = (cur == LAST_CHAR) ? FIRST_CHAR : cur + 8'd1;
    end else if (dn && !up) begin
      nxt = (cur == FIRST_CHAR) ? LAST_CHAR : cur - 8'd1;
    end
    return nxt;
  endfunction

  assign sel_step_d = cursor_step(sel_q, BtnU, BtnD);
  assign cnt_inc_d  = cnt_q + 3'd1;

`ifndef WORDLE_TX_BACKSPACE_EN
  logic unused_btnl;
  assign unused_btnl = BtnL;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= QIDLE;
      sel_q   <= FIRST_CHAR;
      curr_q  <= 8'h00;
      valid_q <= 1'b0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      bs_q    <= 1'b0;
    end else if (Start) begin
      // A new guess discards any pending token and the partial word.
      state_q <= QSEL;
      sel_q   <= FIRST_CHAR;
      valid_q <= 1'b0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b0;
      bs_q    <= 1'b0;
    end else begin
      case (state_q)
        QIDLE: begin
          state_q <= QIDLE;
        end
        QSEL: begin
          if (BtnC) begin
            curr_q  <= sel_q;
            valid_q <= 1'b1;
            bs_q    <= 1'b0;
            state_q <= QSEND;
          end
`ifdef WORDLE_TX_BACKSPACE_EN
          else if (BtnL && (cnt_q != 3'd0)) begin
            curr_q  <= BS_CHAR;
            valid_q <= 1'b1;
            bs_q    <= 1'b1;
            state_q <= QSEND;
          end
`endif
          else begin
            sel_q <= sel_step_d;
          end
        end
        QSEND: begin
          if (valid_q && Ack) begin
            valid_q <= 1'b0;
            sel_q   <= FIRST_CHAR;
            if (bs_q) begin
              cnt_q   <= cnt_q - 3'd1;
              bs_q    <= 1'b0;
              state_q <= QSEL;
            end else if (cnt_inc_d == WORD_LEN_C) begin
              cnt_q   <= cnt_inc_d;
              done_q  <= 1'b1;
              state_q <= QFULL;
            end else begin
              cnt_q   <= cnt_inc_d;
              state_q <= QSEL;
            end
          end
        end
        QFULL: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= QIDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_letter   = sel_q;
  assign curr_letter  = curr_q;
  assign letter_valid = valid_q;
  assign letter_count = cnt_q;
  assign word_done    = done_q;

`ifndef SYNTHESIS
  always @(posedge Clk) begin
    if (!reset) begin
      assert (cnt_q <= WORD_LEN_C);
      assert (valid_q == (state_q == QSEND));
      assert ((sel_q >= FIRST_CHAR) && (sel_q <= LAST_CHAR));
    end
  end
`endif

endmodule

// File: tb/tb_wordle_letter_tx.sv
// Randomized and directed stimulus for wordle_letter_tx, checked against a letter-index reference model.
module tb_wordle_letter_tx;

  logic       Clk = 1'b0;
  logic       reset;
  logic       Start, BtnU, BtnD, BtnC, BtnL, Ack;
  logic [7:0] sel_letter, curr_letter;
  logic       letter_valid;
  logic [2:0] letter_count;
  logic       word_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: guess progress kept as a letter index and plain counters.
  typedef enum int {M_IDLE, M_PICK, M_OFFER, M_FULL} mode_t;
  mode_t m_mode;
  int    m_idx;
  int    m_count;
  int    m_curr;
  bit    m_valid;
  bit    m_done;
  bit    m_is_bs;

`ifdef WORDLE_TX_BACKSPACE_EN
  localparam bit BS_ON = 1'b1;
`else
  localparam bit BS_ON = 1'b0;
`endif

  wordle_letter_tx dut (
    .Clk(Clk), .reset(reset), .Start(Start), .BtnU(BtnU), .BtnD(BtnD),
    .BtnC(BtnC), .BtnL(BtnL), .Ack(Ack), .sel_letter(sel_letter),
    .curr_letter(curr_letter), .letter_valid(letter_valid),
    .letter_count(letter_count), .word_done(word_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_count = 0; m_curr = 0;
    m_valid = 0; m_done = 0; m_is_bs = 0;
  endtask

  task automatic model_apply(input bit s, input bit u, input bit d, input bit c, input bit l, input bit a);
    if (s) begin
      m_mode = M_PICK; m_idx = 0; m_count = 0; m_valid = 0; m_done = 0; m_is_bs = 0;
    end else if (m_mode == M_PICK) begin
      if (c) begin
        m_curr = 65 + m_idx; m_valid = 1; m_is_bs = 0; m_mode = M_OFFER;
      end else if (BS_ON && l && m_count > 0) begin
        m_curr = 8; m_valid = 1; m_is_bs = 1; m_mode = M_OFFER;
      end else if (u && !d) begin
        m_idx = (m_idx + 1) % 26;
      end else if (d && !u) begin
        m_idx = (m_idx + 25) % 26;
      end
    end else if (m_mode == M_OFFER && a) begin
      m_valid = 0; m_idx = 0;
      if (m_is_bs) begin
        m_count = m_count - 1; m_mode = M_PICK; m_is_bs = 0;
      end else begin
        m_count = m_count + 1;
        if (m_count == 5) begin m_mode = M_FULL; m_done = 1; end
        else m_mode = M_PICK;
      end
    end
  endtask

  task automatic compare_all(input string where);
    chk({where, ".sel"},   sel_letter,   65 + m_idx);
    chk({where, ".curr"},  curr_letter,  m_curr);
    chk({where, ".valid"}, letter_valid, m_valid);
    chk({where, ".count"}, letter_count, m_count);
    chk({where, ".done"},  word_done,    m_done);
  endtask

  task automatic step(input bit s, input bit u, input bit d, input bit c, input bit l, input bit a);
    @(negedge Clk);
    Start = s; BtnU = u; BtnD = d; BtnC = c; BtnL = l; Ack = a;
    @(posedge Clk);
    model_apply(s, u, d, c, l, a);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic commit_letter(input int target);
    for (int k = 0; k < 26 && m_idx != target; k++) begin
      if (((target - m_idx + 26) % 26) <= 13) step(0, 1, 0, 0, 0, 0);
      else step(0, 0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("commit.curr", curr_letter, 65 + target);
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    Start = 0; BtnU = 0; BtnD = 0; BtnC = 0; BtnL = 0; Ack = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.sel",   sel_letter,   8'h41);
    chk("rst.curr",  curr_letter,  8'h00);
    chk("rst.valid", letter_valid, 1'b0);
    chk("rst.count", letter_count, 3'd0);
    chk("rst.done",  word_done,    1'b0);
    @(negedge Clk);
    reset = 1'b0;

    // Idle ignores everything but Start.
    step(0, 1, 0, 1, 1, 1);
    chk("idle.valid", letter_valid, 1'b0);

    // Scenario 1: commit 'A' and accept it.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t1.curr", curr_letter, 8'h41);
    chk("t1.valid", letter_valid, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    chk("t1.count", letter_count, 3'd1);

    // Scenario 2: ring wrap, cancel, BtnC priority.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("t2.wrapdn", sel_letter, 8'h5A);
    step(0, 1, 0, 0, 0, 0);
    chk("t2.wrapup", sel_letter, 8'h41);
    step(0, 1, 1, 0, 0, 0);
    chk("t2.cancel", sel_letter, 8'h41);
    step(0, 1, 0, 1, 0, 0);
    chk("t2.cprio.curr", curr_letter, 8'h41);
    chk("t2.cprio.sel",  sel_letter,  8'h41);
    step(0, 0, 0, 0, 0, 1);

    // Scenario 3: R E N E W fills the word.
    step(1, 0, 0, 0, 0, 0);
    commit_letter(17); commit_letter(4); commit_letter(13);
    commit_letter(4);  commit_letter(22);
    chk("t3.done", word_done, 1'b1);
    chk("t3.count", letter_count, 3'd5);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 1, 1);
    chk("t3.ignore", letter_valid, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    chk("t3.restart.done", word_done, 1'b0);
    chk("t3.restart.count", letter_count, 3'd0);

    // Scenario 4: held offer stays stable under button noise.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, k[0], ~k[0], k[1], 0, 0);
    chk("t4.curr", curr_letter, 8'h42);
    chk("t4.valid", letter_valid, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t4.count", letter_count, 3'd1);

    // Scenario 6: backspace behaviour at count 2 and count 0.
    commit_letter(2);
    chk("t6.count2", letter_count, 3'd2);
    step(0, 0, 0, 0, 1, 0);
    chk("t6.bs.valid", letter_valid, BS_ON);
    step(0, 0, 0, 0, 0, 1);
    chk("t6.bs.count", letter_count, BS_ON ? 3'd1 : 3'd2);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t6.bs0.valid", letter_valid, 1'b0);

    // Scenario 5: Start during an offer, then async reset mid-offer.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("t5.start.valid", letter_valid, 1'b0);
    chk("t5.start.count", letter_count, 3'd0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge Clk);
    Start = 0; BtnU = 0; BtnD = 0; BtnC = 0; BtnL = 0; Ack = 0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_all("t5.arst");
    @(negedge Clk);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    idle_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
